mem_word_loader: RTL

//  Write side of the 10-bit-address / 32-bit-data single-port block RAM that the

---
 rtl/mem_word_loader_if.sv | 30 +++
 rtl/mem_word_loader.sv | 132 +++++++++++++
 2 files changed

// File: rtl/mem_word_loader_if.sv
// Byte-stream input and RAM write-port bundle for mem_word_loader.
interface mem_word_loader_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   word_count;
  logic [7:0]        in_byte;
  logic              in_valid;
  logic              in_ready;
  logic              ena;
  logic              wea;
  logic [ADDR_W-1:0] addra;
  logic [DATA_W-1:0] dina;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   words_written;

  modport master (
    output start, abort, base_addr, word_count, in_byte, in_valid,
    input  in_ready, ena, wea, addra, dina, busy, done, words_written
  );

  modport slave (
    input  start, abort, base_addr, word_count, in_byte, in_valid,
    output in_ready, ena, wea, addra, dina, busy, done, words_written
  );
endinterface

// File: rtl/mem_word_loader.sv
// Packs a little-endian byte stream into DATA_W-bit words and writes them to
// consecutive block-RAM addresses starting at a latched base address.
module mem_word_loader #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic               clka,
  input  logic               rst,
  mem_word_loader_if.slave   bus
);

  localparam int BYTES = DATA_W / 8;
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(BYTES - 1);
  localparam logic [IDX_W-1:0]  IDX_ONE  = 1;
  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
  localparam logic [ADDR_W:0]   CNT_ONE  = 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_WRITE,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic [DATA_W-1:0] dina_q, dina_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] addra_q, addra_d;
  logic [ADDR_W:0]   rem_q, rem_d;
  logic [ADDR_W:0]   wcnt_q, wcnt_d;
  logic              ena_q, busy_q, done_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    word_d  = word_q;
    dina_d  = dina_q;
    addr_d  = addr_q;
    addra_d = addra_q;
    rem_d   = rem_q;
    wcnt_d  = wcnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (!bus.abort && bus.start) begin
          wcnt_d = '0;
          if (bus.word_count != '0) begin
            addr_d  = bus.base_addr;
            rem_d   = bus.word_count;
            idx_d   = '0;
            word_d  = '0;
            state_d = S_COLLECT;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_COLLECT: begin
        if (bus.abort) begin
          idx_d   = '0;
          word_d  = '0;
          state_d = S_IDLE;
        end else if (bus.in_valid) begin
          word_d[idx_q*8 +: 8] = bus.in_byte;
          if (idx_q == LAST_IDX) begin
            // Output registers are loaded here so the write appears the cycle after the last byte.
            idx_d   = '0;
            dina_d  = word_d;
            addra_d = addr_q;
            state_d = S_WRITE;
          end else begin
            idx_d = idx_q + IDX_ONE;
          end
        end
      end
      S_WRITE: begin
        addr_d = addr_q + ADDR_ONE;
        wcnt_d = wcnt_q + CNT_ONE;
        rem_d  = rem_q - CNT_ONE;
        if (bus.abort)
          state_d = S_IDLE;
        else if (rem_q == CNT_ONE)
          state_d = S_DONE;
        else
          state_d = S_COLLECT;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clka) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      word_q  <= '0;
      dina_q  <= '0;
      addr_q  <= '0;
      addra_q <= '0;
      rem_q   <= '0;
      wcnt_q  <= '0;
      ena_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      dina_q  <= dina_d;
      addr_q  <= addr_d;
      addra_q <= addra_d;
      rem_q   <= rem_d;
      wcnt_q  <= wcnt_d;
      ena_q   <= (state_d == S_WRITE);
      busy_q  <= (state_d == S_COLLECT) || (state_d == S_WRITE);
      done_q  <= (state_d == S_DONE);
    end
  end

  assign bus.in_ready      = (state_q == S_COLLECT);
  assign bus.ena           = ena_q;
  assign bus.wea           = ena_q;
  assign bus.addra         = addra_q;
  assign bus.dina          = dina_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.words_written = wcnt_q;

endmodule
